exec_stage: RTL and testbench

Execute stage of the 8-bit datapath: accepts decoded ALU instructions over a valid/ready handshake and reads operands from an internal 8×8 register file. Drives the combinational ALU from registered operands, then writes the ALU result back to the register file and a writeback trace port. Sits between the decoder (upstream) and the ALU (alongside), and owns the architectural registers and zero flag.

---
 rtl/exec_stage.sv | 93 +++++++++
 tb/tb_exec_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// exec_stage: execute stage of the 8-bit datapath.
// Accepts decoded ALU instructions over valid/ready, reads operands from the
// internal 8x8 register file, registers them toward the external ALU and
// writes the ALU result back one cycle later.
// Optional feature macro: FORWARD_EN (bypass alu_result on RAW hazards
// instead of stalling for one cycle).
module exec_stage (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_op,
   input  logic [2:0] in_ra,
   input  logic [2:0] in_rb,
   input  logic       in_use_imm,
   input  logic [7:0] in_imm,
   input  logic [2:0] in_rd,
   output logic [2:0] alu_op,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   input  logic [7:0] alu_result,
   output logic       wb_valid,
   output logic [2:0] wb_rd,
   output logic [7:0] wb_data,
   output logic       zero_flag,
   input  logic [2:0] dbg_addr,
   output logic [7:0] dbg_data
);

   logic [7:0] rf [8];
   logic       e_valid;
   logic [2:0] e_rd;
   logic       accept;
   logic       hit_a;
   logic       hit_b;
   logic [7:0] op_a;
   logic [7:0] op_b;

   assign hit_a    = e_valid && (e_rd == in_ra);
   assign hit_b    = e_valid && !in_use_imm && (e_rd == in_rb);
   assign accept   = in_valid && in_ready;
   assign dbg_data = rf[dbg_addr];

`ifdef FORWARD_EN
   // Bypass: the instruction in E has not written yet, so take its result straight from the ALU.
   always_comb begin
      op_a     = hit_a ? alu_result : rf[in_ra];
      op_b     = in_use_imm ? in_imm : (hit_b ? alu_result : rf[in_rb]);
      in_ready = !reset;
   end
`else
   // Stall: hold off the dependent instruction one cycle until the write has landed.
   always_comb begin
      op_a     = rf[in_ra];
      op_b     = in_use_imm ? in_imm : rf[in_rb];
      in_ready = !reset && !(hit_a || hit_b);
   end
`endif

   // E-stage registers, register file write and writeback trace, all cleared on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            rf[i] <= '0;
         end
         e_valid   <= 1'b0;
         e_rd      <= '0;
         alu_op    <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         wb_valid  <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         zero_flag <= 1'b0;
      end else begin
         e_valid  <= accept;
         wb_valid <= e_valid;
         if (accept) begin
            e_rd   <= in_rd;
            alu_op <= in_op;
            alu_a  <= op_a;
            alu_b  <= op_b;
         end
         if (e_valid) begin
            rf[e_rd]  <= alu_result;
            wb_rd     <= e_rd;
            wb_data   <= alu_result;
            zero_flag <= (alu_result == 8'h00);
         end
      end
   end

endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed bench for exec_stage with a writeback scoreboard.
// The bench supplies the combinational ALU and a program-order register model.
module tb_exec_stage;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op;
   logic [2:0] in_ra;
   logic [2:0] in_rb;
   logic       in_use_imm;
   logic [7:0] in_imm;
   logic [2:0] in_rd;
   logic [2:0] alu_op;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_result;
   logic       wb_valid;
   logic [2:0] wb_rd;
   logic [7:0] wb_data;
   logic       zero_flag;
   logic [2:0] dbg_addr;
   logic [7:0] dbg_data;

   typedef struct packed {
      logic [2:0] rd;
      logic [7:0] data;
   } wb_t;

   wb_t        sb_q [$];
   logic [7:0] mregs [8];
   int         n_vec  = 0;
   int         n_miss = 0;
   int         stalls;
   int         exp_stalls;

   exec_stage dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_ra      (in_ra),
      .in_rb      (in_rb),
      .in_use_imm (in_use_imm),
      .in_imm     (in_imm),
      .in_rd      (in_rd),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .zero_flag  (zero_flag),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Environment ALU: 8-bit wrap-around, CMP yields 1 on equality.
   function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return {a[6:0], 1'b0};
         3'd6:    return b;
         default: return (a == b) ? 8'h01 : 8'h00;
      endcase
   endfunction

   assign alu_result = alu_f(alu_op, alu_a, alu_b);

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      n_vec++;
      assert (observed === expected)
      else begin
         n_miss++;
         $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drive one instruction, record its expected writeback, and wait for it to be accepted.
   task automatic applyStimulus(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                                input logic use_imm, input logic [7:0] imm, input logic [2:0] rd,
                                output int stall_cnt);
      logic [7:0] b;
      logic [7:0] r;
      b = use_imm ? imm : mregs[rb];
      r = alu_f(op, mregs[ra], b);
      mregs[rd] = r;
      sb_q.push_back('{rd: rd, data: r});
      in_valid   = 1'b1;
      in_op      = op;
      in_ra      = ra;
      in_rb      = rb;
      in_use_imm = use_imm;
      in_imm     = imm;
      in_rd      = rd;
      stall_cnt  = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (in_ready) break;
         stall_cnt++;
      end
      checkOutput("in_ready_accept", {7'b0, in_ready}, 8'h01);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Scoreboard: every writeback pulse must match the oldest outstanding instruction.
   always @(negedge clk) begin
      wb_t exp;
      if (wb_valid) begin
         n_vec++;
         assert (sb_q.size() > 0)
         else begin
            n_miss++;
            $error("[TB] FAIL wb_spurious: wb_valid=1 rd=%0d data=%h, expected no writeback", wb_rd, wb_data);
         end
         if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            checkOutput("wb_rd", {5'b0, wb_rd}, {5'b0, exp.rd});
            checkOutput("wb_data", wb_data, exp.data);
            checkOutput("wb_zero_flag", {7'b0, zero_flag}, {7'b0, (exp.data == 8'h00)});
         end
      end
   end

   initial begin
      reset      = 1'b1;
      in_valid   = 1'b0;
      in_op      = '0;
      in_ra      = '0;
      in_rb      = '0;
      in_use_imm = 1'b0;
      in_imm     = '0;
      in_rd      = '0;
      dbg_addr   = '0;
      for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
`ifdef FORWARD_EN
      exp_stalls = 0;
`else
      exp_stalls = 1;
`endif

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("in_ready_in_reset", {7'b0, in_ready}, 8'h00);
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         checkOutput($sformatf("reset_r%0d", i), dbg_data, 8'h00);
      end
      @(negedge clk);
      checkOutput("reset_wb_valid", {7'b0, wb_valid}, 8'h00);
      checkOutput("reset_zero_flag", {7'b0, zero_flag}, 8'h00);
      checkOutput("ready_after_reset", {7'b0, in_ready}, 8'h01);
      @(posedge clk);
      #1;

      // Single ADD r1 = r0 + 5, with latency check
      $display("[TB] single ADD");
      dbg_addr = 3'd1;
      applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 8'h05, 3'd1, stalls);
      @(negedge clk);
      checkOutput("add_wb_t1", {7'b0, wb_valid}, 8'h00);
      @(negedge clk);
      checkOutput("add_wb_t2", {7'b0, wb_valid}, 8'h01);
      checkOutput("add_wb_data", wb_data, 8'h05);
      checkOutput("add_dbg_r1", dbg_data, 8'h05);
      @(posedge clk);
      #1;

      // Back-to-back RAW: r1 = r0+5 then r2 = r1-5
      $display("[TB] back-to-back RAW");
      applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 8'h05, 3'd1, stalls);
      applyStimulus(3'd1, 3'd1, 3'd0, 1'b1, 8'h05, 3'd2, stalls);
      checkOutput("raw_stall_cycles", 8'(stalls), 8'(exp_stalls));
      repeat (3) @(negedge clk);
      dbg_addr = 3'd2;
      #1 checkOutput("raw_dbg_r2", dbg_data, 8'h00);
      checkOutput("raw_zero_flag", {7'b0, zero_flag}, 8'h01);
      @(posedge clk);
      #1;

      // Wrap: r3 = 0xFF, then r3 = r3 + 1
      $display("[TB] wrap-around");
      applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 8'hFF, 3'd3, stalls);
      applyStimulus(3'd0, 3'd3, 3'd0, 1'b1, 8'h01, 3'd3, stalls);
      repeat (3) @(negedge clk);
      dbg_addr = 3'd3;
      #1 checkOutput("wrap_dbg_r3", dbg_data, 8'h00);
      checkOutput("wrap_zero_flag", {7'b0, zero_flag}, 8'h01);
      @(posedge clk);
      #1;

      // Register-register CMP: r4 = 5, r5 = (r1 == r4)
      $display("[TB] register-register CMP");
      applyStimulus(3'd0, 3'd0, 3'd0, 1'b1, 8'h05, 3'd4, stalls);
      applyStimulus(3'd7, 3'd1, 3'd4, 1'b0, 8'hAA, 3'd5, stalls);
      checkOutput("cmp_rb_stall_cycles", 8'(stalls), 8'(exp_stalls));
      repeat (3) @(negedge clk);
      dbg_addr = 3'd5;
      #1 checkOutput("cmp_dbg_r5", dbg_data, 8'h01);
      checkOutput("cmp_zero_flag", {7'b0, zero_flag}, 8'h00);
      checkOutput("drained_before_reset", 8'(sb_q.size()), 8'h00);
      @(posedge clk);
      #1;

      // Accept ADD r4 = r0 + 7, then reset while it is in E
      $display("[TB] reset with instruction in flight");
      in_valid   = 1'b1;
      in_op      = 3'd0;
      in_ra      = 3'd0;
      in_use_imm = 1'b1;
      in_imm     = 8'h07;
      in_rd      = 3'd4;
      @(negedge clk);
      checkOutput("inflight_accept", {7'b0, in_ready}, 8'h01);
      @(posedge clk);
      #1;
      reset    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("inflight_ready_in_reset", {7'b0, in_ready}, 8'h00);
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("inflight_no_wb", {7'b0, wb_valid}, 8'h00);
      end
      dbg_addr = 3'd4;
      #1 checkOutput("inflight_dbg_r4", dbg_data, 8'h00);
      checkOutput("inflight_zero_flag", {7'b0, zero_flag}, 8'h00);
      checkOutput("scoreboard_empty", 8'(sb_q.size()), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
